// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: buffers {pc, instruction} pairs from the fetch stage
// and hands them to ID in order over a valid/ready handshake.
module if_fetch_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INST_WIDTH  = 32,
    parameter int unsigned FREE_MARGIN = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ce_i,
    input  logic [ADDR_WIDTH-1:0]    pc_i,
    input  logic [INST_WIDTH-1:0]    inst_i,
    input  logic                     flush_i,
    input  logic                     id_ready_i,
    output logic                     id_valid_o,
    output logic [ADDR_WIDTH-1:0]    id_pc_o,
    output logic [INST_WIDTH-1:0]    id_inst_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     stallreq_o,
    output logic                     overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MARGIN   = CNT_W'(FREE_MARGIN);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;

    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [CNT_W-1:0] free_slots;

    assign full = (count_reg == FULL_CNT);
    assign pop  = id_valid_o && id_ready_i && !flush_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = ce_i && !flush_i && (!full || pop);
    assign drop = ce_i && !flush_i && full && !pop;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
            if (drop) begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset; the head is masked by id_valid_o instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= pc_i;
            inst_mem[wr_ptr_reg] <= inst_i;
        end
    end

    assign free_slots = FULL_CNT - count_reg;

    assign id_valid_o = (count_reg != '0);
    assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr_reg]   : '0;
    assign id_inst_o  = id_valid_o ? inst_mem[rd_ptr_reg] : '0;
    assign count_o    = count_reg;
    assign stallreq_o = (free_slots <= MARGIN);
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=4, FREE_MARGIN=2).
module tb_if_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ce_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic        flush_i = 1'b0;
    logic        id_ready_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [2:0]  count_o;
    logic        stallreq_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_queue #(
        .DEPTH(4), .ADDR_WIDTH(32), .INST_WIDTH(32), .FREE_MARGIN(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ce_i(ce_i), .pc_i(pc_i), .inst_i(inst_i),
        .flush_i(flush_i), .id_ready_i(id_ready_i), .id_valid_o(id_valid_o),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .count_o(count_o),
        .stallreq_o(stallreq_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        ce_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (count_o !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        n_cmp++;
        if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
        n_cmp++;
        if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_head got=%h/%h exp=0/0", id_pc_o, id_inst_o);
        end
        n_cmp++;
        if (stallreq_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got stall=%b ovf=%b exp=0/0", stallreq_o, overflow_o);
        end
        $display("reset: count=%0d valid=%b", count_o, id_valid_o);
    endtask

    // Push 0x0/0x4/0x8 while ID always ready: one-cycle latency, count never above 1.
    task automatic test_passthrough();
        logic [31:0] pcs [3];
        logic [31:0] insts [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        insts[0] = 32'h11; insts[1] = 32'h22; insts[2] = 32'h33;
        id_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ce_i = 1'b1; pc_i = pcs[i]; inst_i = insts[i];
            if (i == 0) begin
                #1;
                n_cmp++;
                if (id_valid_o !== 1'b0) begin n_bad++; $display("FAIL pass_no_comb_path got=%b exp=0", id_valid_o); end
            end
            tick();
            n_cmp++;
            if (id_valid_o !== 1'b1 || id_pc_o !== pcs[i] || id_inst_o !== insts[i]) begin
                n_bad++;
                $display("FAIL pass_head%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                         i, id_valid_o, id_pc_o, id_inst_o, pcs[i], insts[i]);
            end
            n_cmp++;
            if (count_o !== 3'd1) begin n_bad++; $display("FAIL pass_count%0d got=%0d exp=1", i, count_o); end
            $display("pass: ID sees pc=%h inst=%h count=%0d", id_pc_o, id_inst_o, count_o);
        end
        ce_i = 1'b0;
        tick();
        n_cmp++;
        if (id_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_bad++; $display("FAIL pass_drain got v=%b cnt=%0d exp v=0 cnt=0", id_valid_o, count_o);
        end
        id_ready_i = 1'b0;
    endtask

    // Fill 4 entries with ID stalled, then a 5th push is dropped.
    task automatic test_fill_overflow();
        logic [2:0] exp_cnt;
        logic       exp_stall;
        id_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ce_i = 1'b1; pc_i = 32'(4 * i); inst_i = 32'hA0 + 32'(i);
            tick();
            exp_cnt   = 3'(i + 1);
            exp_stall = (i + 1 >= 2);
            n_cmp++;
            if (count_o !== exp_cnt || stallreq_o !== exp_stall || overflow_o !== 1'b0) begin
                n_bad++;
                $display("FAIL fill%0d got cnt=%0d stall=%b ovf=%b exp cnt=%0d stall=%b ovf=0",
                         i, count_o, stallreq_o, overflow_o, exp_cnt, exp_stall);
            end
            $display("fill: push pc=%h count=%0d stall=%b", pc_i, count_o, stallreq_o);
        end
        pc_i = 32'h10; inst_i = 32'hBAD;
        tick();
        ce_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd4 || overflow_o !== 1'b1) begin
            n_bad++; $display("FAIL overflow got cnt=%0d ovf=%b exp cnt=4 ovf=1", count_o, overflow_o);
        end
        n_cmp++;
        if (id_pc_o !== 32'h0 || id_inst_o !== 32'hA0) begin
            n_bad++; $display("FAIL overflow_head got pc=%h inst=%h exp pc=0 inst=a0", id_pc_o, id_inst_o);
        end
        $display("overflow: dropped pc=10 count=%0d ovf=%b", count_o, overflow_o);
    endtask

    // Full queue with simultaneous push and pop: occupancy holds at 4.
    task automatic test_full_push_pop();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ce_i = 1'b1; pc_i = 32'h20 + 32'(4 * i); inst_i = pc_i ^ 32'hF000;
            tick();
        end
        id_ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            pc_i = 32'h2C + 32'(4 * k); inst_i = pc_i ^ 32'hF000;
            tick();
            exp_pc = 32'h20 + 32'(4 * k);
            n_cmp++;
            if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
                n_bad++; $display("FAIL fullpp_cnt%0d got cnt=%0d ovf=%b exp cnt=4 ovf=0", k, count_o, overflow_o);
            end
            n_cmp++;
            if (id_pc_o !== exp_pc || id_inst_o !== (exp_pc ^ 32'hF000)) begin
                n_bad++; $display("FAIL fullpp_head%0d got pc=%h inst=%h exp pc=%h inst=%h",
                                  k, id_pc_o, id_inst_o, exp_pc, exp_pc ^ 32'hF000);
            end
            $display("fullpp: head pc=%h count=%0d", id_pc_o, count_o);
        end
        ce_i = 1'b0; id_ready_i = 1'b0;
    endtask

    // Flush wins over a coincident push and pop; pointers restart at zero.
    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ce_i = 1'b1; pc_i = 32'h40 + 32'(4 * i); inst_i = 32'h400 + 32'(i);
            tick();
        end
        flush_i = 1'b1; ce_i = 1'b1; id_ready_i = 1'b1; pc_i = 32'h4C; inst_i = 32'hDEAD;
        tick();
        flush_i = 1'b0; ce_i = 1'b0; id_ready_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd0 || id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || stallreq_o !== 1'b0) begin
            n_bad++; $display("FAIL flush got cnt=%0d v=%b inst=%h stall=%b exp 0/0/0/0",
                              count_o, id_valid_o, id_inst_o, stallreq_o);
        end
        tick();
        n_cmp++;
        if (id_valid_o !== 1'b0 || id_inst_o === 32'hDEAD) begin
            n_bad++; $display("FAIL flush_ghost got v=%b inst=%h exp v=0", id_valid_o, id_inst_o);
        end
        ce_i = 1'b1; pc_i = 32'h50; inst_i = 32'h55;
        tick();
        ce_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd1 || id_pc_o !== 32'h50 || id_inst_o !== 32'h55) begin
            n_bad++; $display("FAIL flush_restart got cnt=%0d pc=%h inst=%h exp cnt=1 pc=50 inst=55",
                              count_o, id_pc_o, id_inst_o);
        end
        $display("flush: restart head pc=%h count=%0d", id_pc_o, count_o);
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
    endtask

    // Ten back-to-back entries stream through, wrapping both pointers.
    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        id_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ce_i = 1'b1; pc_i = 32'h100 + 32'(4 * i); inst_i = 32'hC000 + 32'(i);
            tick();
            exp_pc = 32'h100 + 32'(4 * i);
            n_cmp++;
            if (id_valid_o !== 1'b1 || id_pc_o !== exp_pc || id_inst_o !== 32'hC000 + 32'(i) || count_o !== 3'd1) begin
                n_bad++; $display("FAIL b2b%0d got v=%b pc=%h inst=%h cnt=%0d exp v=1 pc=%h inst=%h cnt=1",
                                  i, id_valid_o, id_pc_o, id_inst_o, count_o, exp_pc, 32'hC000 + 32'(i));
            end
            $display("b2b: ID sees pc=%h inst=%h", id_pc_o, id_inst_o);
        end
        ce_i = 1'b0;
        tick();
        id_ready_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd0) begin n_bad++; $display("FAIL b2b_drain got=%0d exp=0", count_o); end
    endtask

    // Reset asserted between edges clears everything before the next edge.
    task automatic test_async_reset();
        id_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ce_i = 1'b1; pc_i = 32'h200 + 32'(4 * i); inst_i = 32'h7;
            tick();
        end
        ce_i = 1'b0; id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd3 || overflow_o !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre got cnt=%0d ovf=%b exp cnt=3 ovf=1", count_o, overflow_o);
        end
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if (count_o !== 3'd0 || id_valid_o !== 1'b0 || stallreq_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_bad++; $display("FAIL arst got cnt=%0d v=%b stall=%b ovf=%b exp 0/0/0/0",
                              count_o, id_valid_o, stallreq_o, overflow_o);
        end
        $display("arst: count=%0d valid=%b ovf=%b", count_o, id_valid_o, overflow_o);
        #2 rst_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_fill_overflow();
        test_full_push_pop();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction fetch queue between the PC generator / instruction ROM and the ID stage.
- Captures each {pc, instruction} pair fetched while the PC generator's chip-enable is active.
- Buffers up to DEPTH entries and presents them in order to ID with a valid/ready handshake.
- Raises a stall request back to the pipeline controller before it can overflow, and discards all contents on a branch/exception flush.

Parameters:
DEPTH, 4, number of queue entries; power of two, at least 4
ADDR_WIDTH, 32, PC width (matches `ADDR_WIDTH)
INST_WIDTH, 32, instruction word width
FREE_MARGIN, 2, stall request asserts when free slots <= FREE_MARGIN; covers the fetch already in flight when the PC freezes

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
ce_i  input  1  fetch valid: PC generator chip-enable; a push is requested on every cycle it is high
pc_i  input  ADDR_WIDTH  PC of the instruction on inst_i
inst_i  input  INST_WIDTH  instruction ROM read data, aligned with pc_i in the same cycle
flush_i  input  1  discard all queued entries
id_ready_i  input  1  ID stage accepts the head entry this cycle
id_valid_o  output  1  head entry valid
id_pc_o  output  ADDR_WIDTH  head entry PC
id_inst_o  output  INST_WIDTH  head entry instruction
count_o  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
stallreq_o  output  1  request to freeze PC generator (drives stall_i[0] via controller)
overflow_o  output  1  sticky error: a push was dropped

Behaviour:
- Reset (async, rst_i=1): write/read pointers=0, count=0, overflow_o=0. With count=0: id_valid_o=0, id_pc_o=0, id_inst_o=0 (NOP), stallreq_o=0. Storage contents need no reset.
- Pop: occurs when id_valid_o && id_ready_i. Read pointer advances by 1 and wraps modulo DEPTH.
- Push: occurs when ce_i && (count<DEPTH || pop). {pc_i, inst_i} is written at the write pointer; the write pointer advances and wraps modulo DEPTH.
- Count update: count += push - pop.
- Latency: an entry pushed in cycle N is visible on id_* in cycle N+1 (queue was empty). No combinational path from ce_i/pc_i/inst_i to id_*.
- Head outputs are driven from the storage entry at the read pointer and are valid only while id_valid_o=1. When count=0: id_valid_o=0 and id_pc_o/id_inst_o forced to 0.
- Simultaneous push+pop:
  - Full: both occur, count stays DEPTH, nothing dropped.
  - Empty: pop cannot occur (valid=0); the push lands.
- Full without pop: if ce_i=1 while count=DEPTH and no pop, the entry is dropped, state is unchanged, and overflow_o sets. overflow_o holds 1 until reset; flush does not clear it.
- Flush: flush_i=1 has priority over push and pop in the same cycle. Pointers and count clear to 0, the incoming entry is not stored, and id_valid_o=0 in the next cycle.
- stallreq_o = (DEPTH - count) <= FREE_MARGIN. It is decoded from the registered count only (glitch-free, no combinational dependence on inputs).
- id_ready_i is ignored while id_valid_o=0.
- Reset mid-operation: all entries lost immediately and asynchronously; outputs take reset values without waiting for a clock edge.

Test Plan:
1. Reset, then ce_i=1 with pc 0x0,0x4,0x8 and inst 0x11,0x22,0x33, id_ready_i=1 -> id_valid_o rises 1 cycle after first push; ID sees (0x0,0x11),(0x4,0x22),(0x8,0x33) in order; count_o never exceeds 1.
2. id_ready_i=0, ce_i=1 for 4 cycles (DEPTH=4) -> count_o 1,2,3,4; stallreq_o=1 once count_o=2; overflow_o stays 0. A 5th push -> dropped, overflow_o=1, head still pc 0x0.
3. Full queue, ce_i=1 and id_ready_i=1 for 3 cycles -> count_o stays 4, outputs advance one entry per cycle, no drop, overflow_o=0.
4. 3 entries queued, then flush_i=1 with ce_i=1 and id_ready_i=1 in the same cycle -> next cycle count_o=0, id_valid_o=0, id_inst_o=0; the flushed-cycle instruction never appears.
5. Continuous push/pop for 10 entries starting at pc 0x100 -> read/write pointers wrap; ID receives pc 0x100..0x124 in order.
6. Assert rst_i asynchronously between clock edges with count_o=3 and overflow_o=1 -> count_o=0, id_valid_o=0, stallreq_o=0, overflow_o=0 before the next clock edge.
